// File: rtl/player_input_pkg.sv
// player_input_pkg: shared types and constants for the player input stage.
package player_input_pkg;

  // Fire-control states; WAIT_RELEASE is only reachable without autofire.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    FIRE         = 2'd1,
    COOLDOWN     = 2'd2,
    WAIT_RELEASE = 2'd3
  } fire_state_t;

  // HID usage IDs for the keys the game listens to.
  localparam logic [7:0] HID_SPACE = 8'd44;
  localparam logic [7:0] HID_LEFT  = 8'd80;
  localparam logic [7:0] HID_RIGHT = 8'd79;

  localparam int unsigned NUM_BUTTONS = 3;
  localparam int unsigned BTN_FIRE    = 2;
  localparam int unsigned BTN_LEFT    = 1;
  localparam int unsigned BTN_RIGHT   = 0;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchroniser plus stable-count debouncer for one
// active-low push-button. 'pressed' is the accepted (debounced) level.
module button_debounce
  import player_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic Clk,
  input  logic reset_h,
  input  logic raw_n,
  output logic pressed
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sample;

  // Synchronise the asynchronous pin; released (1) out of reset.
  always_ff @(posedge Clk) begin
    if (reset_h) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], raw_n};
    end
  end

  assign sample = ~sync_q[1];

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge Clk) begin
    if (reset_h) begin
      pressed <= 1'b0;
      cnt_q   <= '0;
    end else if (sample == pressed) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      pressed <= sample;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/player_input.sv
// player_input: conditions board buttons and the USB keycode into clean
// left/right levels and a frame-rate-limited one-cycle shoot pulse.
// Build option: PLAYER_INPUT_AUTOFIRE_EN -- when defined, holding fire
// re-shoots after every cooldown; otherwise each shot needs a fresh press.
module player_input
  import player_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = 500000,
  parameter int unsigned FIRE_COOLDOWN_FRAMES = 15,
  parameter logic [7:0]  KC_FIRE              = HID_SPACE,
  parameter logic [7:0]  KC_LEFT              = HID_LEFT,
  parameter logic [7:0]  KC_RIGHT             = HID_RIGHT
) (
  input  logic       Clk,
  input  logic       reset_h,
  input  logic [2:0] key_n,
  input  logic [7:0] keycode,
  input  logic       VGA_VS,
  output logic       shoot,
  output logic       left,
  output logic       right,
  output logic       fire_ready
);

  localparam int unsigned CD_W = $clog2(FIRE_COOLDOWN_FRAMES + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(FIRE_COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

  logic [NUM_BUTTONS-1:0] btn_pressed;
  logic [7:0]             kc_q;
  logic                   fire_req;
  logic                   left_req;
  logic                   right_req;

  logic [1:0]             vs_sync_q;
  logic                   vs_prev_q;
  logic                   tick_q;

  fire_state_t            state_q;
  fire_state_t            state_d;
  logic [CD_W-1:0]        cd_cnt_q;
  logic [CD_W-1:0]        cd_cnt_d;
  logic                   shoot_d;
  logic                   ready_d;

  // One synchronising debouncer per board button.
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .Clk    (Clk),
      .reset_h(reset_h),
      .raw_n  (key_n[i]),
      .pressed(btn_pressed[i])
    );
  end

  // Register the NIOS keycode so decode sees a clean, aligned value.
  always_ff @(posedge Clk) begin
    if (reset_h) begin
      kc_q <= '0;
    end else begin
      kc_q <= keycode;
    end
  end

  assign fire_req  = btn_pressed[BTN_FIRE]  | (kc_q == KC_FIRE);
  assign left_req  = btn_pressed[BTN_LEFT]  | (kc_q == KC_LEFT);
  assign right_req = btn_pressed[BTN_RIGHT] | (kc_q == KC_RIGHT);

  // Opposing directions cancel; only an unambiguous request moves the ship.
  always_ff @(posedge Clk) begin
    if (reset_h) begin
      left  <= 1'b0;
      right <= 1'b0;
    end else begin
      left  <= left_req & ~right_req;
      right <= right_req & ~left_req;
    end
  end

  // Bring VGA_VS into the Clk domain and strobe once per falling edge.
  always_ff @(posedge Clk) begin
    if (reset_h) begin
      vs_sync_q <= 2'b11;
      vs_prev_q <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      vs_sync_q <= {vs_sync_q[0], VGA_VS};
      vs_prev_q <= vs_sync_q[1];
      tick_q    <= vs_prev_q & ~vs_sync_q[1];
    end
  end

  // Fire FSM state, cooldown counter and registered outputs.
  always_ff @(posedge Clk) begin
    if (reset_h) begin
      state_q    <= IDLE;
      cd_cnt_q   <= '0;
      shoot      <= 1'b0;
      fire_ready <= 1'b1;
    end else begin
      state_q    <= state_d;
      cd_cnt_q   <= cd_cnt_d;
      shoot      <= shoot_d;
      fire_ready <= ready_d;
    end
  end

  // Fire FSM next state: one shot, then a frame-counted cooldown.
  always_comb begin
    state_d  = state_q;
    cd_cnt_d = cd_cnt_q;
    shoot_d  = 1'b0;
    ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (fire_req) state_d = FIRE;
      end
      FIRE: begin
        cd_cnt_d = CD_LOAD;
        state_d  = COOLDOWN;
      end
      COOLDOWN: begin
        if (tick_q) begin
          if (cd_cnt_q > CD_ONE) begin
            cd_cnt_d = cd_cnt_q - CD_ONE;
          end else begin
            cd_cnt_d = '0;
`ifdef PLAYER_INPUT_AUTOFIRE_EN
            state_d  = IDLE;
`else
            state_d  = fire_req ? WAIT_RELEASE : IDLE;
`endif
          end
        end
      end
`ifndef PLAYER_INPUT_AUTOFIRE_EN
      WAIT_RELEASE: begin
        if (!fire_req) state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    shoot_d = (state_q == FIRE);
    ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_player_input.sv
// tb_player_input: randomized stimulus against a history-based reference
// model; expected outputs are queued per edge and checked by a monitor.
module tb_player_input;

  localparam int unsigned DC   = 4;
  localparam int unsigned FCF  = 2;
  localparam int          NCYC = 4000;
  localparam logic [7:0]  KF   = 8'd44;
  localparam logic [7:0]  KL   = 8'd80;
  localparam logic [7:0]  KR   = 8'd79;

  logic       clk = 1'b0;
  logic       reset_h;
  logic [2:0] key_n;
  logic [7:0] keycode;
  logic       vga_vs;
  logic       shoot, left, right, fire_ready;

  always #5 clk = ~clk;

  player_input #(
    .DEBOUNCE_CYCLES     (DC),
    .FIRE_COOLDOWN_FRAMES(FCF)
  ) dut (
    .Clk       (clk),
    .reset_h   (reset_h),
    .key_n     (key_n),
    .keycode   (keycode),
    .VGA_VS    (vga_vs),
    .shoot     (shoot),
    .left      (left),
    .right     (right),
    .fire_ready(fire_ready)
  );

  typedef struct {
    int n;
    bit shoot;
    bit left;
    bit right;
    bit ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   shots_model = 0;
  int   shots_dut = 0;

  // Input histories, indexed by the clock edge that samples them.
  bit       rst_h [NCYC];
  bit [2:0] key_h [NCYC];
  bit       vs_h  [NCYC];
  bit [7:0] kc_h  [NCYC];
  bit       freq_h[NCYC];
  bit       lreq_h[NCYC];
  bit       rreq_h[NCYC];
  bit       tick_h[NCYC];

  // Reference state: accepted button levels and shot-gating bookkeeping.
  bit db[3];
  int last_flip[3];
  bit armed, firing, hold;
  int frames_left;
  bit shoot_m;

  function automatic bit rst_at(input int n);
    return (n < 0) ? 1'b1 : rst_h[n];
  endfunction

  // Pressed-sense of a button as seen after the two-stage synchroniser.
  function automatic bit btn_seen(input int b, input int n);
    if (rst_at(n - 1) || rst_at(n - 2)) return 1'b0;
    return ~key_h[n-2][b];
  endfunction

  function automatic bit vs_s2_after(input int n);
    if (rst_at(n) || rst_at(n - 1)) return 1'b1;
    return vs_h[n-1];
  endfunction

  function automatic bit vs_prev_after(input int n);
    if (rst_at(n)) return 1'b1;
    return vs_s2_after(n - 1);
  endfunction

  // Predict the outputs just after edge n and queue them.
  task automatic model_edge(input int n);
    bit   all_diff;
    bit   pf, pt;
    bit [7:0] kcq;
    exp_t e;
    for (int b = 0; b < 3; b++) begin
      if (rst_h[n]) begin
        db[b] = 1'b0;
        last_flip[b] = n;
      end else if (n - last_flip[b] >= int'(DC)) begin
        all_diff = 1'b1;
        for (int j = 0; j < int'(DC); j++)
          if (btn_seen(b, n - j) == db[b]) all_diff = 1'b0;
        if (all_diff) begin
          db[b] = ~db[b];
          last_flip[b] = n;
        end
      end
    end
    kcq = rst_h[n] ? 8'd0 : kc_h[n];
    freq_h[n] = db[2] | (kcq == KF);
    lreq_h[n] = db[1] | (kcq == KL);
    rreq_h[n] = db[0] | (kcq == KR);
    tick_h[n] = rst_h[n] ? 1'b0 : (vs_prev_after(n - 1) & ~vs_s2_after(n - 1));

    pf = (n > 0) ? freq_h[n-1] : 1'b0;
    pt = (n > 0) ? tick_h[n-1] : 1'b0;
    e.n = n;
    if (rst_h[n] || n == 0) begin
      e.left  = 1'b0;
      e.right = 1'b0;
    end else begin
      e.left  = lreq_h[n-1] & ~rreq_h[n-1];
      e.right = rreq_h[n-1] & ~lreq_h[n-1];
    end

    if (rst_h[n]) begin
      armed = 1'b1; firing = 1'b0; hold = 1'b0; frames_left = 0; shoot_m = 1'b0;
    end else begin
      shoot_m = firing;
      if (armed) begin
        if (pf) begin armed = 1'b0; firing = 1'b1; end
      end else if (firing) begin
        firing = 1'b0;
        frames_left = FCF;
      end else if (frames_left > 0) begin
        if (pt) begin
          frames_left--;
          if (frames_left == 0) begin
`ifdef PLAYER_INPUT_AUTOFIRE_EN
            armed = 1'b1;
`else
            if (pf) hold = 1'b1;
            else    armed = 1'b1;
`endif
          end
        end
      end else if (hold) begin
        if (!pf) begin hold = 1'b0; armed = 1'b1; end
      end
    end
    e.shoot = shoot_m;
    e.ready = armed;
    if (shoot_m) shots_model++;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every presented cycle against the queued prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (shoot) shots_dut++;
      checks++;
      if (shoot !== e.shoot) begin
        failures++;
        $display("FAIL shoot edge=%0d got=%b exp=%b", e.n, shoot, e.shoot);
      end
      checks++;
      if (left !== e.left) begin
        failures++;
        $display("FAIL left edge=%0d got=%b exp=%b", e.n, left, e.left);
      end
      checks++;
      if (right !== e.right) begin
        failures++;
        $display("FAIL right edge=%0d got=%b exp=%b", e.n, right, e.right);
      end
      checks++;
      if (fire_ready !== e.ready) begin
        failures++;
        $display("FAIL fire_ready edge=%0d got=%b exp=%b", e.n, fire_ready, e.ready);
      end
    end
  end

  // Stimulus: reset with buttons held, then randomized buttons/keycode/vsync.
  initial begin
    int key_hold[3];
    bit [2:0] key_val;
    int kc_hold, vs_cnt, vs_period, rst_len, sel;
    bit [7:0] kc_val;
    bit rst_v;

    reset_h = 1'b1;
    key_n   = 3'b000;
    keycode = 8'd0;
    vga_vs  = 1'b1;
    key_hold = '{0, 0, 0};
    key_val  = 3'b000;
    kc_hold  = 0;
    kc_val   = 8'd0;
    vs_cnt   = 0;
    vs_period = 12;
    rst_len  = 0;
    for (int b = 0; b < 3; b++) begin db[b] = 1'b0; last_flip[b] = -1; end
    armed = 1'b1; firing = 1'b0; hold = 1'b0; frames_left = 0; shoot_m = 1'b0;

    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      if (n < 3) begin
        rst_v = 1'b1;
      end else if (n < 30) begin
        rst_v = 1'b0;
      end else begin
        if (rst_len > 0) begin
          rst_v = 1'b1;
          rst_len--;
        end else if ($urandom_range(0, 399) == 0) begin
          rst_v = 1'b1;
          rst_len = $urandom_range(0, 2);
        end else begin
          rst_v = 1'b0;
        end
        for (int b = 0; b < 3; b++) begin
          if (key_hold[b] == 0) begin
            key_val[b]  = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            key_hold[b] = $urandom_range(1, 14);
          end
          key_hold[b]--;
        end
        if (kc_hold == 0) begin
          sel = $urandom_range(0, 4);
          case (sel)
            0:       kc_val = 8'd0;
            1:       kc_val = KF;
            2:       kc_val = KL;
            3:       kc_val = KR;
            default: kc_val = 8'($urandom_range(0, 255));
          endcase
          kc_hold = $urandom_range(1, 40);
        end
        kc_hold--;
      end

      reset_h = rst_v;
      key_n   = (n < 30) ? 3'b000 : key_val;
      keycode = (n < 30) ? 8'd0 : kc_val;
      vga_vs  = (vs_cnt < 2) ? 1'b0 : 1'b1;
      vs_cnt++;
      if (vs_cnt >= vs_period) begin
        vs_cnt = 0;
        vs_period = $urandom_range(8, 16);
      end

      rst_h[n] = reset_h;
      key_h[n] = key_n;
      vs_h[n]  = vga_vs;
      kc_h[n]  = keycode;
      model_edge(n);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (shots_dut != shots_model) begin
      failures++;
      $display("FAIL shot_count got=%0d exp=%0d", shots_dut, shots_model);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
